// File: rtl/out_pass4_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : out_pass4_rr_arbiter
// Description : Burst arbiter sharing one registered 4-bit output pin group
//               among fabric requesters (round-robin or fixed priority).
// Revision    : 1.0 - initial release
// ============================================================================
module out_pass4_rr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 4,
    parameter int MAX_BURST    = 4,
    parameter int NoConfigBits = 2
) (
    input  logic                      UserCLK,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         O,
    output logic                      O_valid,
    output logic [1:0]                O_src,
    input  logic [NoConfigBits-1:0]   ConfigBits
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] c_LAST_IDX = 2'(NUM_REQ - 1);
    localparam logic [3:0] c_BEAT_MAX = 4'(MAX_BURST - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [1:0]         r_grant;
    logic [1:0]         w_grantNext;
    logic [1:0]         r_rrPtr;
    logic [1:0]         w_rrPtrNext;
    logic [1:0]         w_ptrAfter;
    logic [3:0]         r_beatCnt;
    logic [3:0]         w_beatNext;
    logic               r_limitEn;
    logic               w_limitNext;
    logic               w_xfer;
    logic               w_burstEnd;
    logic [NUM_REQ-1:0] w_grantOh;
    logic [NUM_REQ-1:0] w_others;
    logic [NUM_REQ-1:0] w_pickMask;
    logic [1:0]         w_pickStart;
    logic [2:0]         w_pick;

    // Returns {found, index}; descending scan so the smallest offset from start wins.
    function automatic logic [2:0] pickWinner(
        input logic [NUM_REQ-1:0] mask,
        input logic [1:0]         start,
        input logic               rrMode
    );
        logic       found;
        logic [1:0] idx;
        int         pos;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = rrMode ? (int'(start) + k) : k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (mask[pos]) begin
                found = 1'b1;
                idx   = 2'(pos);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        w_grantOh          = '0;
        w_grantOh[r_grant] = 1'b1;
    end

    assign w_xfer      = (r_state == S_GRANT) && req_valid[r_grant];
    assign w_burstEnd  = w_xfer && (req_last[r_grant] ||
                                    (r_limitEn && (r_beatCnt == c_BEAT_MAX)));
    assign w_ptrAfter  = (r_grant == c_LAST_IDX) ? 2'd0 : r_grant + 2'd1;
    assign w_others    = req_valid & ~w_grantOh;

    // At burst end the ender only competes when nobody else is asking.
    assign w_pickMask  = (r_state == S_IDLE) ? req_valid
                       : ((|w_others) ? w_others : req_valid);
    assign w_pickStart = (r_state == S_IDLE) ? r_rrPtr : w_ptrAfter;
    assign w_pick      = pickWinner(w_pickMask, w_pickStart, ConfigBits[0]);

    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_rrPtrNext = r_rrPtr;
        w_beatNext  = r_beatCnt;
        w_limitNext = r_limitEn;
        case (r_state)
            S_IDLE: begin
                if (w_pick[2]) begin
                    w_stateNext = S_GRANT;
                    w_grantNext = w_pick[1:0];
                    w_beatNext  = 4'd0;
                    w_limitNext = ConfigBits[1];
                end
            end
            S_GRANT: begin
                if (w_burstEnd) begin
                    w_rrPtrNext = w_ptrAfter;
                    w_beatNext  = 4'd0;
                    w_limitNext = ConfigBits[1];
                    if (w_pick[2]) begin
                        w_grantNext = w_pick[1:0];
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else if (w_xfer) begin
                    w_beatNext = r_beatCnt + 4'd1;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_grant   <= 2'd0;
            r_rrPtr   <= 2'd0;
            r_beatCnt <= 4'd0;
            r_limitEn <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_grant   <= w_grantNext;
            r_rrPtr   <= w_rrPtrNext;
            r_beatCnt <= w_beatNext;
            r_limitEn <= w_limitNext;
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_GRANT) req_ready = w_grantOh;
    end

    // Pin flops: data and source hold between beats, only O_valid pulses.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            O       <= '0;
            O_valid <= 1'b0;
            O_src   <= 2'd0;
        end else begin
            O_valid <= w_xfer;
            if (w_xfer) begin
                O     <= req_data[r_grant*DATA_W +: DATA_W];
                O_src <= r_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_pass4_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_out_pass4_rr_arbiter
// Description : Randomised scoreboard bench for out_pass4_rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_pass4_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 4;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] src;
    } beat_t;

    logic        UserCLK = 1'b0;
    logic        resetn  = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [1:0]  ConfigBits = 2'b01;
    logic [3:0]  req_ready;
    logic [3:0]  O;
    logic        O_valid;
    logic [1:0]  O_src;

    out_pass4_rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .MAX_BURST   (MAX_BURST),
        .NoConfigBits(2)
    ) dut (
        .UserCLK   (UserCLK),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .O         (O),
        .O_valid   (O_valid),
        .O_src     (O_src),
        .ConfigBits(ConfigBits)
    );

    always #5 UserCLK = ~UserCLK;

    int nCompared = 0;
    int nMismatch = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: who owns the pins, where round-robin resumes, beats so far.
    beat_t      expQ[$];
    int         owner     = -1;
    int         ptr       = 0;
    int         beats     = 0;
    bit         limitOn   = 1'b0;
    logic [3:0] expReady  = '0;
    logic [3:0] mOthers;

    function automatic int pick(input logic [3:0] mask, input int start, input bit rr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = rr ? (start + k) % NUM_REQ : k;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            owner   = -1;
            ptr     = 0;
            beats   = 0;
            limitOn = 1'b0;
            expQ.delete();
        end else if (owner < 0) begin
            if (req_valid != 4'd0) begin
                owner   = pick(req_valid, ptr, ConfigBits[0]);
                beats   = 0;
                limitOn = ConfigBits[1];
            end
        end else if (req_valid[owner]) begin
            expQ.push_back({req_data[owner*DATA_W +: DATA_W], 2'(owner)});
            beats++;
            if (req_last[owner] || (limitOn && beats == MAX_BURST)) begin
                mOthers = req_valid & ~(4'b0001 << owner);
                ptr     = (owner + 1) % NUM_REQ;
                owner   = pick((mOthers != 4'd0) ? mOthers : req_valid, ptr, ConfigBits[0]);
                beats   = 0;
                limitOn = ConfigBits[1];
            end
        end
        expReady = (owner < 0) ? 4'd0 : (4'b0001 << owner);
    end

    // Monitor: every beat must appear exactly one edge after it was accepted.
    logic [3:0] lastO   = '0;
    logic [1:0] lastSrc = '0;
    beat_t      got;

    always @(negedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            lastO   = '0;
            lastSrc = '0;
        end else begin
            check("req_ready", 32'(req_ready), 32'(expReady));
            check("O_valid", 32'(O_valid), 32'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                got     = expQ.pop_front();
                lastO   = got.data;
                lastSrc = got.src;
                if (O_valid) begin
                    check("O", 32'(O), 32'(got.data));
                    check("O_src", 32'(O_src), 32'(got.src));
                end
            end else if (!O_valid) begin
                check("O_hold", 32'(O), 32'(lastO));
                check("O_src_hold", 32'(O_src), 32'(lastSrc));
            end
        end
    end

    task automatic randSeg(input int n, input int pValid, input int pLast,
                           input logic [1:0] cfg, input bit cfgRand);
        ConfigBits = cfg;
        repeat (n) begin
            @(posedge UserCLK);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = ($urandom_range(99) < pValid);
                req_last[i]  = ($urandom_range(99) < pLast);
            end
            req_data = 16'($urandom);
            if (cfgRand && $urandom_range(7) == 0) ConfigBits = 2'($urandom);
        end
    endtask

    task automatic fixSeg(input int n, input logic [3:0] v, input logic [3:0] l,
                          input logic [1:0] cfg);
        ConfigBits = cfg;
        repeat (n) begin
            @(posedge UserCLK);
            #1;
            req_valid = v;
            req_last  = l;
            req_data  = 16'($urandom);
        end
    endtask

    task automatic midReset();
        @(posedge UserCLK);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_O", 32'(O), 32'd0);
        check("rst_O_valid", 32'(O_valid), 32'd0);
        check("rst_O_src", 32'(O_src), 32'd0);
        repeat (2) @(posedge UserCLK);
        #3;
        resetn = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge UserCLK);
        #3;
        resetn = 1'b1;
        fixSeg(10, 4'b0000, 4'b0000, 2'b01);
        fixSeg(24, 4'b1111, 4'b0000, 2'b01);
        fixSeg(1,  4'b1111, 4'b1111, 2'b01);
        randSeg(150, 90, 45, 2'b01, 1'b0);
        fixSeg(20, 4'b0101, 4'b1111, 2'b00);
        fixSeg(8,  4'b0100, 4'b1111, 2'b00);
        fixSeg(30, 4'b1010, 4'b0000, 2'b11);
        randSeg(60, 95, 20, 2'b11, 1'b0);
        fixSeg(12, 4'b0100, 4'b0000, 2'b01);
        fixSeg(6,  4'b0000, 4'b0000, 2'b01);
        fixSeg(6,  4'b0110, 4'b0000, 2'b01);
        randSeg(300, 70, 30, 2'b01, 1'b1);
        fixSeg(6,  4'b1111, 4'b0000, 2'b01);
        midReset();
        fixSeg(12, 4'b1111, 4'b0000, 2'b01);
        randSeg(200, 60, 25, 2'b10, 1'b1);
        fixSeg(1,  4'b1111, 4'b1111, 2'b01);
        fixSeg(4,  4'b0000, 4'b0000, 2'b01);
        @(negedge UserCLK);
        #1;
        check("queue_drain", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
`default_nettype wire
